// File: rtl/rtc_time_counter.sv
// 24-hour HH:MM:SS time-of-day counter with a 1 Hz prescaler and a SET mode.
// In SET mode the selected field can be stepped up or down with single-cycle pulses.
module rtc_time_counter #(
  parameter int unsigned DIV = 100000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       set_mode,
  input  logic [1:0] set_sel,
  input  logic       inc,
  input  logic       dec,
  output logic [5:0] seconds,
  output logic [5:0] minutes,
  output logic [5:0] hours,
  output logic       sec_tick,
  output logic       day_wrap,
  output logic       editing
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] PMAX = CW'(DIV - 1);

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_SET = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] presc_q, presc_d;
  logic [5:0]    sec_q, sec_d;
  logic [5:0]    min_q, min_d;
  logic [5:0]    hr_q, hr_d;
  logic          tick_q, tick_d;
  logic          wrap_q, wrap_d;

  // Out-of-range values (e.g. after X-injection) collapse to 0 on their next update.
  function automatic logic [5:0] step_up(input logic [5:0] v, input logic [5:0] max);
    return (v >= max) ? 6'd0 : v + 6'd1;
  endfunction

  function automatic logic [5:0] step_down(input logic [5:0] v, input logic [5:0] max);
    if (v > max)
      return 6'd0;
    else if (v == 6'd0)
      return max;
    else
      return v - 6'd1;
  endfunction

  always_comb begin
    state_d = set_mode ? ST_SET : ST_RUN;
    presc_d = presc_q;
    sec_d   = sec_q;
    min_d   = min_q;
    hr_d    = hr_q;
    tick_d  = 1'b0;
    wrap_d  = 1'b0;
    if (state_q == ST_RUN) begin
      if (presc_q >= PMAX) begin
        presc_d = '0;
        tick_d  = 1'b1;
        sec_d   = step_up(sec_q, 6'd59);
        if (sec_q == 6'd59) begin
          min_d = step_up(min_q, 6'd59);
          if (min_q == 6'd59) begin
            hr_d = step_up(hr_q, 6'd23);
            wrap_d = (hr_q == 6'd23);
          end
        end
      end else begin
        presc_d = presc_q + CW'(1);
      end
    end else begin
      // A pulse arriving on the same edge set_mode drops is ignored.
      presc_d = '0;
      if (set_mode && (inc ^ dec)) begin
        case (set_sel)
          2'd0:    sec_d = inc ? step_up(sec_q, 6'd59) : step_down(sec_q, 6'd59);
          2'd1:    min_d = inc ? step_up(min_q, 6'd59) : step_down(min_q, 6'd59);
          2'd2:    hr_d  = inc ? step_up(hr_q, 6'd23)  : step_down(hr_q, 6'd23);
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_RUN;
      presc_q <= '0;
      sec_q   <= '0;
      min_q   <= '0;
      hr_q    <= '0;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      sec_q   <= sec_d;
      min_q   <= min_d;
      hr_q    <= hr_d;
      tick_q  <= tick_d;
      wrap_q  <= wrap_d;
    end
  end

  assign seconds  = sec_q;
  assign minutes  = min_q;
  assign hours    = hr_q;
  assign sec_tick = tick_q;
  assign day_wrap = wrap_q;
  assign editing  = (state_q == ST_SET);

endmodule

// File: tb/tb_rtc_time_counter.sv
// Bench for rtc_time_counter: reference model keeps time of day as a plain
// seconds-since-midnight integer plus a cycle count toward the next second.
module tb_rtc_time_counter;
  localparam int unsigned DIV = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       set_mode;
  logic [1:0] set_sel;
  logic       inc, dec;
  logic [5:0] seconds, minutes, hours;
  logic       sec_tick, day_wrap, editing;

  rtc_time_counter #(.DIV(DIV)) dut (
    .clk(clk), .reset(reset), .set_mode(set_mode), .set_sel(set_sel),
    .inc(inc), .dec(dec), .seconds(seconds), .minutes(minutes), .hours(hours),
    .sec_tick(sec_tick), .day_wrap(day_wrap), .editing(editing)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  int m_t, m_pc;
  bit m_set, m_tick, m_wrap;

  logic [20:0] obs;
  logic [20:0] e;
  assign obs = {seconds, minutes, hours, sec_tick, day_wrap, editing};

  function automatic logic [20:0] expv();
    return {6'(m_t % 60), 6'((m_t / 60) % 60), 6'(m_t / 3600), m_tick, m_wrap, m_set};
  endfunction

  task automatic model_reset();
    m_t = 0; m_pc = 0; m_set = 0; m_tick = 0; m_wrap = 0;
  endtask

  task automatic model_edge(input bit sm, input logic [1:0] sel, input bit i, input bit d);
    int h, m, s, delta;
    if (!m_set) begin
      if (m_pc == DIV - 1) begin
        m_pc = 0; m_t = (m_t + 1) % 86400; m_tick = 1; m_wrap = (m_t == 0);
      end else begin
        m_pc++; m_tick = 0; m_wrap = 0;
      end
    end else begin
      m_pc = 0; m_tick = 0; m_wrap = 0;
      if (sm && (i != d) && sel != 2'd3) begin
        h = m_t / 3600; m = (m_t / 60) % 60; s = m_t % 60;
        delta = i ? 1 : -1;
        if (sel == 2'd0) s = (s + 60 + delta) % 60;
        if (sel == 2'd1) m = (m + 60 + delta) % 60;
        if (sel == 2'd2) h = (h + 24 + delta) % 24;
        m_t = h * 3600 + m * 60 + s;
      end
    end
    m_set = sm;
  endtask

  task automatic step(input bit sm, input logic [1:0] sel, input bit i, input bit d);
    set_mode = sm; set_sel = sel; inc = i; dec = d;
    @(posedge clk);
    model_edge(sm, sel, i, d);
    @(negedge clk);
    inc = 1'b0; dec = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    set_mode = 0; inc = 0; dec = 0; set_sel = 0;
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 6; k++) step(0, 0, 0, 0);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (obs !== 21'd0) $display("FAIL reset_async: got %b expected %b", obs, 21'd0); else n_pass++;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step(0, 0, 0, 0);
      e = expv();
      n_checks++;
      if (obs !== e) $display("FAIL reset_run_%0d: got %b expected %b", k, obs, e); else n_pass++;
      n_checks++;
      if (k < 4 && sec_tick !== 1'b0) $display("FAIL reset_early_tick_%0d: got %b expected 0", k, sec_tick);
      else if (k == 4 && (sec_tick !== 1'b1 || seconds !== 6'd1))
        $display("FAIL reset_first_tick: got tick=%b sec=%0d expected tick=1 sec=1", sec_tick, seconds);
      else n_pass++;
    end
  endtask

  task automatic test_cascade();
    do_reset();
    step(1, 0, 0, 0);
    step(1, 0, 0, 1);
    n_checks++;
    if (seconds !== 6'd59) $display("FAIL cascade_preload: got %0d expected 59", seconds); else n_pass++;
    step(0, 0, 0, 0);
    for (int k = 1; k <= 4; k++) begin
      step(0, 0, 0, 0);
      e = expv();
      n_checks++;
      if (obs !== e) $display("FAIL cascade_%0d: got %b expected %b", k, obs, e); else n_pass++;
    end
    n_checks++;
    if ({hours, minutes, seconds, sec_tick, day_wrap} !== {6'd0, 6'd1, 6'd0, 1'b1, 1'b0})
      $display("FAIL cascade_result: got %0d:%0d:%0d t=%b w=%b expected 0:1:0 t=1 w=0",
               hours, minutes, seconds, sec_tick, day_wrap);
    else n_pass++;
  endtask

  task automatic test_full_wrap();
    do_reset();
    step(1, 0, 0, 0);
    step(1, 2, 0, 1);
    step(1, 1, 0, 1);
    step(1, 0, 0, 1);
    n_checks++;
    if ({hours, minutes, seconds} !== {6'd23, 6'd59, 6'd59})
      $display("FAIL wrap_preload: got %0d:%0d:%0d expected 23:59:59", hours, minutes, seconds);
    else n_pass++;
    step(0, 0, 0, 0);
    for (int k = 1; k <= 5; k++) begin
      step(0, 0, 0, 0);
      e = expv();
      n_checks++;
      if (obs !== e) $display("FAIL wrap_%0d: got %b expected %b", k, obs, e); else n_pass++;
      n_checks++;
      if (k == 4 && {hours, minutes, seconds, sec_tick, day_wrap} !== {18'd0, 1'b1, 1'b1})
        $display("FAIL wrap_result: got %0d:%0d:%0d t=%b w=%b expected 0:0:0 t=1 w=1",
                 hours, minutes, seconds, sec_tick, day_wrap);
      else if (k != 4 && day_wrap !== 1'b0)
        $display("FAIL wrap_pulse_%0d: got %b expected 0", k, day_wrap);
      else n_pass++;
    end
  endtask

  task automatic test_set_edit();
    do_reset();
    step(1, 0, 0, 0);
    step(1, 2, 0, 1);
    n_checks++;
    if ({hours, minutes, editing} !== {6'd23, 6'd0, 1'b1})
      $display("FAIL edit_hour_dec: got h=%0d m=%0d ed=%b expected h=23 m=0 ed=1", hours, minutes, editing);
    else n_pass++;
    step(1, 0, 0, 1);
    step(1, 0, 1, 0);
    n_checks++;
    if ({seconds, minutes} !== {6'd0, 6'd0})
      $display("FAIL edit_sec_inc: got s=%0d m=%0d expected s=0 m=0", seconds, minutes);
    else n_pass++;
    step(1, 1, 1, 1);
    step(1, 3, 1, 0);
    e = expv();
    n_checks++;
    if (obs !== e || {hours, minutes, seconds} !== {6'd23, 6'd0, 6'd0})
      $display("FAIL edit_nochange: got %b expected %b", obs, e);
    else n_pass++;
  endtask

  task automatic test_freeze();
    logic [17:0] snap;
    do_reset();
    step(1, 0, 0, 0);
    step(1, 1, 1, 0);
    snap = {seconds, minutes, hours};
    for (int k = 0; k < 20; k++) begin
      step(1, 2'($urandom_range(0, 3)), 0, 0);
      n_checks++;
      if ({seconds, minutes, hours} !== snap || sec_tick !== 1'b0 || editing !== 1'b1)
        $display("FAIL freeze_%0d: got %b expected %b t=0 ed=1", k, obs, {snap, 3'b001});
      else n_pass++;
    end
    step(0, 0, 0, 0);
    n_checks++;
    if (editing !== 1'b0) $display("FAIL freeze_exit_editing: got %b expected 0", editing); else n_pass++;
    for (int k = 1; k <= 4; k++) begin
      step(0, 0, 0, 0);
      n_checks++;
      if (sec_tick !== (k == 4)) $display("FAIL freeze_exit_tick_%0d: got %b expected %b", k, sec_tick, k == 4);
      else n_pass++;
    end
  endtask

  task automatic test_async_reset_set();
    do_reset();
    step(1, 0, 0, 0);
    step(1, 0, 1, 0);
    @(negedge clk);
    set_mode = 1; set_sel = 0; inc = 1;
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (obs !== 21'd0) $display("FAIL set_async_reset: got %b expected %b", obs, 21'd0); else n_pass++;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0; inc = 0; set_mode = 0;
    for (int k = 1; k <= 4; k++) begin
      step(0, 0, 0, 0);
      e = expv();
      n_checks++;
      if (obs !== e) $display("FAIL set_reset_run_%0d: got %b expected %b", k, obs, e); else n_pass++;
    end
  endtask

  task automatic test_exit_inc();
    do_reset();
    step(1, 0, 0, 0);
    step(0, 0, 1, 0);
    n_checks++;
    if ({seconds, editing} !== {6'd0, 1'b0})
      $display("FAIL exit_inc: got s=%0d ed=%b expected s=0 ed=0", seconds, editing);
    else n_pass++;
  endtask

  task automatic test_random();
    bit sm = 0;
    do_reset();
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 19) == 0) sm = ~sm;
      step(sm, 2'($urandom_range(0, 3)), $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
      e = expv();
      n_checks++;
      if (obs !== e) $display("FAIL random_%0d: got %b expected %b", k, obs, e); else n_pass++;
    end
  endtask

  initial begin
    reset = 1'b1; set_mode = 0; set_sel = 0; inc = 0; dec = 0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_cascade();
    test_full_wrap();
    test_set_edit();
    test_freeze();
    test_async_reset_set();
    test_exit_inc();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/rtc_time_counter.md
Name: rtc_time_counter

Overview:
- Time-of-day counter (HH:MM:SS, 24 h) for the VGA monitor.
- Generates 1 Hz ticks from the system clock and drives the 6-bit seconds/minutes/hours values consumed by the two-digit decoders.
- Provides a set mode in which the user steps one selected field up or down with debounced button pulses.

Parameters:
- DIV, 100000000, system clock cycles per second tick; minimum 2. Benches use DIV=4.
- CW, $clog2(DIV), prescaler counter width (derived, not overridden).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- set_mode  in  1  level: 1 = SET state, 0 = RUN state.
- set_sel  in  2  field selected in SET: 0 seconds, 1 minutes, 2 hours, 3 none.
- inc  in  1  one-cycle pulse (debounced upstream): +1 on selected field.
- dec  in  1  one-cycle pulse: -1 on selected field.
- seconds  out  6  0..59, registered.
- minutes  out  6  0..59, registered.
- hours  out  6  0..23, registered.
- sec_tick  out  1  one-cycle pulse, coincident with each seconds advance in RUN.
- day_wrap  out  1  one-cycle pulse, coincident with the 23:59:59 -> 00:00:00 transition.
- editing  out  1  1 while in SET state (for cursor/blink logic downstream).

Behaviour:
- Reset (async, any time, including mid-edit or mid-prescale):
  - seconds = minutes = hours = 0; prescaler = 0.
  - sec_tick = day_wrap = editing = 0.
  - State = RUN.
  - Removing reset takes effect at the first clock edge after deassertion.
- State machine: two states, RUN and SET.
  - RUN -> SET on any edge with set_mode=1; SET -> RUN on any edge with set_mode=0.
  - editing is registered: it is 1 in the cycle after the edge that enters SET.
- RUN:
  - prescaler counts 0..DIV-1.
  - On the edge where prescaler==DIV-1: prescaler <= 0, seconds advance, sec_tick <= 1 for exactly one cycle. Otherwise sec_tick <= 0.
  - Advance rules:
    - seconds 59 -> 0 with minutes +1.
    - minutes 59 -> 0 (on seconds carry) with hours +1.
    - hours 23 -> 0 (on full carry) with day_wrap <= 1 for one cycle.
    - All carries resolve in the same edge: no intermediate value such as 00:60 is ever visible.
  - inc/dec are ignored in RUN.
- SET:
  - prescaler held at 0; no sec_tick; no day_wrap.
  - On an edge with inc=1 and dec=0: the selected field +1, wrapping 59->0 (seconds/minutes) or 23->0 (hours).
  - On an edge with dec=1 and inc=0: the selected field -1, wrapping 0->59 or 0->23.
  - inc and dec both 1: no change. set_sel=3: no change.
  - Edits never carry into neighbouring fields.
  - The updated value is visible on the output the cycle after the pulse edge.
- SET -> RUN: prescaler restarts at 0, so the first sec_tick occurs DIV edges after the exit edge.
- Edge case at the exit edge: if set_mode falls on the same edge that an inc pulse arrives, the state goes to RUN and the inc is ignored (the state at the sampling edge governs).
- Range invariant: outputs never leave their legal range.
  - Downstream decoders' default (out-of-range) branch must never be exercised.
  - Any illegal internal value (e.g. from X-injection) is forced to 0 at the next update of that field.
- Latency:
  - Output registers are the counters themselves.
  - A downstream registered decoder adds one more cycle; the display therefore lags by 1 clk, which is acceptable.

Test Plan:
- Reset and first tick: assert reset mid-count, release with DIV=4, set_mode=0 -> outputs 00:00:00; sec_tick first high on the 4th edge after release; seconds=1 on that same cycle.
- Cascade: preload to 00:00:59 via SET, return to RUN -> after 4 edges reads 00:01:00 with sec_tick=1 and day_wrap=0.
- Full wrap: preload 23:59:59 -> after 4 edges reads 00:00:00 with sec_tick=1 and day_wrap=1, each for exactly one cycle.
- SET editing:
  - set_sel=2, hours=0, one dec pulse -> hours=23 and minutes unchanged.
  - set_sel=0, seconds=59, one inc pulse -> seconds=0 and minutes unchanged.
  - inc and dec high together -> no change.
- SET freeze: hold set_mode=1 for 20 edges with no pulses -> no sec_tick, values constant, editing=1. Deassert set_mode -> editing=0 next cycle; next sec_tick exactly 4 edges after exit.
- Async reset during SET with an inc pulse present -> outputs 0 immediately (before the next clk edge), editing=0, and the state is RUN after release.
